// File: rtl/gnrc_pkg.sv
// Shared generic package: state encoding for the thermometer slew controller.
package gnrc_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRamp
  } gnrc_slew_state_e;

endpackage

// File: rtl/gnrc_bin2therm.sv
// Binary to thermometer encoder: bit k is set iff bin > k.
module gnrc_bin2therm #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]    bin,
  output logic [2**N-2:0] therm
);

  always_comb begin
    therm = '0;
    for (int k = 0; k < 2 ** N - 1; k++) begin
      therm[k] = (int'(bin) > k);
    end
  end

endmodule

// File: rtl/gnrc_therm_slew.sv
// Slew-rate limited thermometer-code driver: ramps or jumps cur_bin_o to a requested target.
module gnrc_therm_slew
  import gnrc_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned M     = 2 ** N - 1,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tgt_valid_i,
  output logic             tgt_ready_o,
  input  logic [N-1:0]     tgt_bin_i,
  input  logic             mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             abort_i,
  output logic [N-1:0]     cur_bin_o,
  output logic [M-1:0]     therm_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [N-1:0] One = N'(1);

  gnrc_slew_state_e state_q, state_d;
  logic [N-1:0]     cur_q, cur_d;
  logic [N-1:0]     tgt_q, tgt_d;
  logic             up_q, up_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [M-1:0]     therm_q;
  logic [M-1:0]     therm_nxt;

  // Encode the next value so therm_o and cur_bin_o update on the same edge.
  gnrc_bin2therm #(
    .N (N)
  ) u_bin2therm (
    .bin   (cur_d),
    .therm (therm_nxt)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    up_d    = up_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tgt_valid_i) begin
          if (mode_i) begin
            cur_d  = tgt_bin_i;
            done_d = 1'b1;
          end else if (tgt_bin_i == cur_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = tgt_bin_i;
            up_d    = (tgt_bin_i > cur_q);
            div_d   = div_i;
            cnt_d   = div_i;
            state_d = StRamp;
          end
        end
      end
      StRamp: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          // Direction is fixed toward a target that differs from cur, so no wrap is possible.
          cur_d = up_q ? (cur_q + One) : (cur_q - One);
          cnt_d = div_q;
          if (cur_d == tgt_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cur_q   <= '0;
      therm_q <= '0;
      tgt_q   <= '0;
      up_q    <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      therm_q <= therm_nxt;
      tgt_q   <= tgt_d;
      up_q    <= up_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign cur_bin_o   = cur_q;
  assign therm_o     = therm_q;
  assign busy_o      = (state_q == StRamp);
  assign tgt_ready_o = (state_q == StIdle);
  assign done_o      = done_q;

endmodule

// File: tb/tb_gnrc_therm_slew.sv
// Bench for gnrc_therm_slew: directed scenarios plus random traffic against an arithmetic model.
module tb_gnrc_therm_slew;

  localparam int N     = 3;
  localparam int M     = 2 ** N - 1;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [N-1:0]     tgt_bin;
  logic             mode;
  logic [DIV_W-1:0] div;
  logic             abort;
  logic [N-1:0]     cur_bin;
  logic [M-1:0]     therm;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  // Reference model: ramp position is a closed-form function of edges since acceptance.
  int m_cur   = 0;
  int m_busy  = 0;
  int m_done  = 0;
  int m_start = 0;
  int m_tgt   = 0;
  int m_div   = 0;
  int m_k     = 0;

  always #5 clk = ~clk;

  gnrc_therm_slew #(
    .N     (N),
    .DIV_W (DIV_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tgt_valid_i (tgt_valid),
    .tgt_ready_o (tgt_ready),
    .tgt_bin_i   (tgt_bin),
    .mode_i      (mode),
    .div_i       (div),
    .abort_i     (abort),
    .cur_bin_o   (cur_bin),
    .therm_o     (therm),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int n, steps;
    if (rst) begin
      m_cur  = 0;
      m_busy = 0;
      m_done = 0;
    end else if (m_busy == 0) begin
      m_done = 0;
      if (tgt_valid) begin
        if (mode) begin
          m_cur  = int'(tgt_bin);
          m_done = 1;
        end else if (int'(tgt_bin) == m_cur) begin
          m_done = 1;
        end else begin
          m_busy  = 1;
          m_start = m_cur;
          m_tgt   = int'(tgt_bin);
          m_div   = int'(div);
          m_k     = 0;
        end
      end
    end else begin
      m_done = 0;
      if (abort) begin
        m_busy = 0;
      end else begin
        m_k++;
        n     = (m_tgt > m_start) ? (m_tgt - m_start) : (m_start - m_tgt);
        steps = m_k / (m_div + 1);
        if (steps > n) steps = n;
        m_cur = (m_tgt > m_start) ? (m_start + steps) : (m_start - steps);
        if (steps == n) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance one edge, then compare everything with the model.
  task automatic cyc(input logic v, input int t, input logic md, input int d, input logic a,
                     input logic r);
    tgt_valid = v;
    tgt_bin   = N'(t);
    mode      = md;
    div       = DIV_W'(d);
    abort     = a;
    rst       = r;
    model_edge();
    @(posedge clk);
    #1;
    chk("cur_bin", int'(cur_bin), m_cur);
    chk("therm", int'(therm), (1 << m_cur) - 1);
    chk("busy", int'(busy), m_busy);
    chk("ready", int'(tgt_ready), 1 - m_busy);
    chk("done", int'(done), m_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    tgt_valid = 1'b0;
    tgt_bin   = '0;
    mode      = 1'b0;
    div       = '0;
    abort     = 1'b0;
    rst       = 1'b1;

    // Reset state.
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    chk("rst_cur", int'(cur_bin), 0);
    chk("rst_ready", int'(tgt_ready), 1);

    // Ramp up 0->5, div=2: steps every third edge, final at edge 15.
    cyc(1'b1, 5, 1'b0, 2, 1'b0, 1'b0);
    idle(2);
    chk("up_first_wait", int'(cur_bin), 0);
    idle(1);
    chk("up_first_step", int'(cur_bin), 1);
    idle(12);
    chk("up_final_cur", int'(cur_bin), 5);
    chk("up_final_therm", int'(therm), 7'b0011111);
    chk("up_final_done", int'(done), 1);
    idle(1);
    chk("up_after_busy", int'(busy), 0);

    // Ramp down 6->2 with div=0.
    cyc(1'b1, 6, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
    idle(4);
    chk("down_cur", int'(cur_bin), 2);
    chk("down_done", int'(done), 1);

    // Direct jump 1->7.
    cyc(1'b1, 1, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b1, 0, 1'b0, 1'b0);
    chk("direct_therm", int'(therm), 7'b1111111);
    chk("direct_ready", int'(tgt_ready), 1);

    // Abort collides with the step to 4 on ramp 0->7, div=1.
    cyc(1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b0, 1, 1'b0, 1'b0);
    idle(7);
    chk("abort_pre_cur", int'(cur_bin), 3);
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    chk("abort_cur", int'(cur_bin), 3);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    cyc(1'b1, 5, 1'b1, 0, 1'b0, 1'b0);
    chk("abort_next_req", int'(cur_bin), 5);

    // Reset mid-ramp at cur=4.
    cyc(1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
    idle(4);
    chk("midrst_pre_cur", int'(cur_bin), 4);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    chk("midrst_cur", int'(cur_bin), 0);
    chk("midrst_ready", int'(tgt_ready), 1);

    // Equal target.
    cyc(1'b1, 3, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b0, 2, 1'b0, 1'b0);
    chk("equal_done", int'(done), 1);
    chk("equal_cur", int'(cur_bin), 3);
    idle(3);
    chk("equal_busy", int'(busy), 0);

    // Random traffic, including aborts and requests while busy.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
